// File: rtl/mem_load_fmt.sv
// mem_load_fmt: in-order load queue that captures memory responses and
// formats them (extend, LWL/LWR merge, misalignment) for writeback.
module mem_load_fmt #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int OFS_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_type,
    input  logic [OFS_W-1:0]  req_ofs,
    input  logic [DATA_W-1:0] req_old,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              req_adel,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_adel,
    output logic              proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] T_LB = 4'd0, T_LBU = 4'd1, T_LH = 4'd2, T_LHU = 4'd3, T_LW = 4'd4,
                           T_LWU = 4'd5, T_LWL = 4'd6, T_LWR = 4'd7, T_LD = 4'd8;

    logic [3:0]        q_type [DEPTH];
    logic [OFS_W-1:0]  q_ofs  [DEPTH];
    logic [DATA_W-1:0] q_old  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [TAG_W-1:0]  q_tag  [DEPTH];
    logic [DEPTH-1:0]  q_adel, q_kill, q_has;
    logic [AW:0]       wr_ptr, rd_ptr, count;
    logic [AW-1:0]     hd, wi, rsp_idx;
    logic              empty, full, push, pop, live, rsp_hit, head_cap, head_rdy;
    logic [DATA_W-1:0] head_data;

    function automatic logic [DATA_W-1:0] fmt(input logic [3:0] t, input logic [OFS_W-1:0] o,
                                              input logic [31:0] old, input logic [DATA_W-1:0] d);
        logic [1:0]  k;
        logic [31:0] w, lwl, lwr;
        logic [15:0] h;
        logic [7:0]  b;
        logic [63:0] r;
        k = o[1:0];
        w = (DATA_W == 64 && o[OFS_W-1]) ? d[DATA_W-1 -: 32] : d[31:0];
        b = w[8*k +: 8];
        h = k[1] ? w[31:16] : w[15:0];
        lwl = k == 2'd0 ? {w[7:0], old[23:0]} : k == 2'd1 ? {w[15:0], old[15:0]} :
              k == 2'd2 ? {w[23:0], old[7:0]} : w;
        lwr = k == 2'd0 ? w : k == 2'd1 ? {old[31:24], w[31:8]} :
              k == 2'd2 ? {old[31:16], w[31:16]} : {old[31:8], w[31:24]};
        case (t)
            T_LB:    r = {{56{b[7]}}, b};
            T_LBU:   r = {56'd0, b};
            T_LH:    r = {{48{h[15]}}, h};
            T_LHU:   r = {48'd0, h};
            T_LWU:   r = {32'd0, w};
            T_LWL:   r = {{32{lwl[31]}}, lwl};
            T_LWR:   r = {{32{lwr[31]}}, lwr};
            T_LD:    r = 64'(d);
            default: r = {{32{w[31]}}, w};
        endcase
        return r[DATA_W-1:0];
    endfunction

    assign hd        = rd_ptr[AW-1:0];
    assign wi        = wr_ptr[AW-1:0];
    assign count     = wr_ptr - rd_ptr;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign req_ready = !full && !flush;
    assign push      = req_valid && req_ready;
    assign req_adel  = req_type > T_LD || (DATA_W == 32 && (req_type == T_LWU || req_type == T_LD)) ||
                       ((req_type == T_LH || req_type == T_LHU) && req_ofs[0]) ||
                       ((req_type == T_LW || req_type == T_LWU) && |req_ofs[1:0]) ||
                       (req_type == T_LD && |req_ofs);

    // responses go to the oldest entry still waiting for memory, killed or not
    always_comb begin
        rsp_hit = 1'b0;
        rsp_idx = hd;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rsp_hit && i < int'(count) && !q_adel[hd + AW'(i)] && !q_has[hd + AW'(i)]) begin
                rsp_hit = 1'b1;
                rsp_idx = hd + AW'(i);
            end
        end
    end

    assign head_cap  = rsp_valid && rsp_hit && rsp_idx == hd;
    assign head_rdy  = !empty && (q_adel[hd] || q_has[hd] || head_cap);
    assign head_data = q_has[hd] ? q_data[hd] : rsp_data;
    assign pop       = head_rdy && (!out_valid || out_ready);
    assign live      = pop && !q_kill[hd] && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_adel    <= '0;
            q_kill    <= '0;
            q_has     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_adel  <= 1'b0;
            proto_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_type[i] <= '0;
                q_ofs[i]  <= '0;
                q_old[i]  <= '0;
                q_data[i] <= '0;
                q_tag[i]  <= '0;
            end
        end else begin
            if (push) begin
                q_type[wi] <= req_type;
                q_ofs[wi]  <= req_ofs;
                q_old[wi]  <= req_old;
                q_tag[wi]  <= req_tag;
                q_adel[wi] <= req_adel;
                q_kill[wi] <= 1'b0;
                q_has[wi]  <= 1'b0;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (rsp_valid && rsp_hit) begin
                q_has[rsp_idx]  <= 1'b1;
                q_data[rsp_idx] <= rsp_data;
            end
            if (rsp_valid && !rsp_hit)
                proto_err <= 1'b1;
            if (flush)
                q_kill <= '1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (live) begin
                out_valid <= 1'b1;
                out_data  <= q_adel[hd] ? '0 : fmt(q_type[hd], q_ofs[hd], q_old[hd][31:0], head_data);
                out_tag   <= q_tag[hd];
                out_adel  <= q_adel[hd];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_load_fmt.sv
// tb_mem_load_fmt: directed and randomized checks of mem_load_fmt at DATA_W=32 and 64.
module tb_mem_load_fmt;
    logic clk = 1'b0, resetn = 1'b0, fl = 1'b0, rv = 1'b0, sv = 1'b0, ordy = 1'b0, sel = 1'b0;
    logic [3:0]  rt = '0;
    logic [2:0]  ro = '0;
    logic [63:0] rold = '0, sd = '0;
    logic [4:0]  rtag = '0;
    int n_chk = 0, n_fail = 0;

    logic        rdy32, adel32, ov32, oa32, pe32, rdy64, adel64, ov64, oa64, pe64;
    logic [31:0] od32;
    logic [63:0] od64;
    logic [4:0]  ot32, ot64;
    logic        req_ready, req_adel, o_valid, o_adel, pe;
    logic [63:0] o_data;
    logic [4:0]  o_tag;

    assign req_ready = sel ? rdy64 : rdy32;
    assign req_adel  = sel ? adel64 : adel32;
    assign o_valid   = sel ? ov64 : ov32;
    assign o_adel    = sel ? oa64 : oa32;
    assign o_data    = sel ? od64 : {32'd0, od32};
    assign o_tag     = sel ? ot64 : ot32;
    assign pe        = sel ? pe64 : pe32;

    mem_load_fmt #(.DATA_W(32)) u32 (
        .clk(clk), .resetn(resetn), .flush(fl && !sel), .req_valid(rv && !sel), .req_ready(rdy32),
        .req_type(rt), .req_ofs(ro[1:0]), .req_old(rold[31:0]), .req_tag(rtag), .req_adel(adel32),
        .rsp_valid(sv && !sel), .rsp_data(sd[31:0]), .out_valid(ov32), .out_ready(ordy),
        .out_data(od32), .out_tag(ot32), .out_adel(oa32), .proto_err(pe32));

    mem_load_fmt #(.DATA_W(64)) u64 (
        .clk(clk), .resetn(resetn), .flush(fl && sel), .req_valid(rv && sel), .req_ready(rdy64),
        .req_type(rt), .req_ofs(ro), .req_old(rold), .req_tag(rtag), .req_adel(adel64),
        .rsp_valid(sv && sel), .rsp_data(sd), .out_valid(ov64), .out_ready(ordy),
        .out_data(od64), .out_tag(ot64), .out_adel(oa64), .proto_err(pe64));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic req(input logic [3:0] t, input logic [2:0] o, input logic [63:0] old, input logic [4:0] tag);
        rv = 1'b1; rt = t; ro = o; rold = old; rtag = tag;
    endtask

    task automatic rsp(input logic [63:0] d);
        sv = 1'b1; sd = d;
    endtask

    task automatic idle();
        rv = 1'b0; sv = 1'b0; fl = 1'b0;
    endtask

    task automatic get(input string nm, input logic [63:0] d, input logic [4:0] tag, input logic a);
        int n = 0;
        smp();
        while (!o_valid && n < 20) begin
            go();
            smp();
            n++;
        end
        chk({nm, "_v"}, o_valid, 1);
        chk({nm, "_d"}, o_data, d);
        chk({nm, "_t"}, o_tag, tag);
        chk({nm, "_a"}, o_adel, a);
        go();
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 1;
        v = v & m;
        return v[n-1] ? (v | ~m) : v;
    endfunction

    // returns {adel, formatted value} straight from the load semantics
    function automatic logic [64:0] model(input int dw, input logic [3:0] t, input logic [2:0] o,
                                          input logic [63:0] old, input logic [63:0] d);
        int k;
        logic [63:0] w, r, lo;
        logic bad;
        k = int'(o) % 4;
        bad = t > 8 || (dw == 32 && (t == 5 || t == 8)) || ((t == 2 || t == 3) && o % 2 != 0) ||
              ((t == 4 || t == 5) && o % 4 != 0) || (t == 8 && o != 0);
        w = (dw == 64 && o >= 4) ? d >> 32 : d & 64'hFFFF_FFFF;
        lo = old & 64'hFFFF_FFFF;
        case (t)
            4'd0:    r = sext(w >> (8 * k), 8);
            4'd1:    r = (w >> (8 * k)) & 64'hFF;
            4'd2:    r = sext(w >> (8 * k), 16);
            4'd3:    r = (w >> (8 * k)) & 64'hFFFF;
            4'd4:    r = sext(w, 32);
            4'd5:    r = w;
            4'd6:    r = sext((w << (24 - 8 * k)) | (lo & ((64'd1 << (24 - 8 * k)) - 1)), 32);
            4'd7:    r = sext((w >> (8 * k)) | (lo & ~(64'hFFFF_FFFF >> (8 * k))), 32);
            default: r = d;
        endcase
        if (bad) r = '0;
        if (dw == 32) r = r & 64'hFFFF_FFFF;
        return {bad, r};
    endfunction

    task automatic run_random(input int ncyc);
        logic [63:0] pend[$], ed[$];
        logic [4:0]  et[$];
        logic        ea[$];
        logic [64:0] m;
        logic [63:0] dat, pd;
        logic [4:0]  pt;
        logic        pv, pa, act;
        int dw;
        dw = sel ? 64 : 32;
        pv = 1'b0; pa = 1'b0; pd = '0; pt = '0;
        for (int c = 0; c < ncyc + 400 && (c < ncyc || ed.size() > 0 || pend.size() > 0); c++) begin
            act  = c < ncyc;
            rv   = act && $urandom_range(0, 99) < 55;
            rt   = 4'($urandom_range(0, 10));
            ro   = 3'($urandom_range(0, dw / 8 - 1));
            rold = {$urandom, $urandom};
            rtag = 5'($urandom);
            fl   = act && $urandom_range(0, 99) < 3;
            ordy = !act || $urandom_range(0, 99) < 65;
            sv   = pend.size() > 0 && $urandom_range(0, 99) < 50;
            if (sv) sd = pend.pop_front();
            smp();
            if (pv) begin
                chk("hold_v", o_valid, 1);
                chk("hold_d", o_data, pd);
                chk("hold_t", o_tag, pt);
                chk("hold_a", o_adel, pa);
            end
            if (o_valid && ordy) begin
                if (ed.size() == 0) chk("extra_out", o_valid, 0);
                else begin
                    chk("out_d", o_data, ed.pop_front());
                    chk("out_t", o_tag, et.pop_front());
                    chk("out_a", o_adel, ea.pop_front());
                end
            end
            if (rv && req_ready) begin
                dat = {$urandom, $urandom};
                m = model(dw, rt, ro, rold, dat);
                chk("req_adel", req_adel, m[64]);
                ed.push_back(m[63:0]);
                et.push_back(rtag);
                ea.push_back(m[64]);
                if (!m[64]) pend.push_back(dat);
            end
            if (fl) begin
                chk("flush_rdy", req_ready, 0);
                ed.delete();
                et.delete();
                ea.delete();
            end
            pv = o_valid && !ordy && !fl;
            pd = o_data; pt = o_tag; pa = o_adel;
            go();
        end
        idle();
        chk("drain", ed.size() + pend.size(), 0);
        chk("rand_pe", pe, 0);
    endtask

    initial begin
        idle();
        go();
        go();
        smp();
        chk("rst_rdy", req_ready, 1);
        chk("rst_v", o_valid, 0);
        chk("rst_d", o_data, 0);
        chk("rst_t", o_tag, 0);
        chk("rst_a", o_adel, 0);
        chk("rst_pe", pe, 0);
        resetn = 1'b1;
        go();

        // byte loads, output held until both have returned
        ordy = 1'b0;
        req(4'd0, 3'd3, 64'd0, 5'd1); go();
        req(4'd1, 3'd3, 64'd0, 5'd2); go();
        idle(); rsp(64'h80FF_1234); go();
        rsp(64'h80FF_1234); go();
        idle(); ordy = 1'b1;
        get("lb", 64'hFFFF_FF80, 5'd1, 1'b0);
        get("lbu", 64'h0000_0080, 5'd2, 1'b0);

        // LWL/LWR with exact one-cycle response latency and no bubble
        req(4'd6, 3'd1, 64'hAABB_CCDD, 5'd3); go();
        req(4'd7, 3'd1, 64'hAABB_CCDD, 5'd4); go();
        idle(); rsp(64'h1122_3344);
        smp(); chk("lwl_early", o_valid, 0); go();
        rsp(64'h1122_3344);
        smp(); chk("lwl_v", o_valid, 1); chk("lwl_d", o_data, 64'h3344_CCDD); chk("lwl_t", o_tag, 3); go();
        idle();
        smp(); chk("lwr_v", o_valid, 1); chk("lwr_d", o_data, 64'hAA11_2233); chk("lwr_t", o_tag, 4); go();

        // misaligned LH retires without a response
        req(4'd2, 3'd1, 64'd0, 5'd7);
        smp(); chk("lh_adel", req_adel, 1); go();
        idle();
        smp(); chk("adel_wait", o_valid, 0); go();
        smp(); chk("adel_v", o_valid, 1); chk("adel_d", o_data, 0); chk("adel_a", o_adel, 1); chk("adel_t", o_tag, 7);
        rt = 4'd8; ro = 3'd0; #1; chk("ld32_adel", req_adel, 1);
        rt = 4'd5; #1; chk("lwu32_adel", req_adel, 1);
        rt = 4'd4; #1; chk("lw_ok", req_adel, 0);
        go();

        // fill, stall, then back-to-back drain
        ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(4'd4, 3'd0, 64'd0, 5'(10 + i));
            smp(); chk("fill_rdy", req_ready, 1); go();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rsp(64'h1000_0000 + 64'(i));
            smp(); if (i == 0) chk("full_rdy", req_ready, 0);
            go();
        end
        idle();
        for (int s = 0; s < 5; s++) begin
            smp(); chk("stall_v", o_valid, 1); chk("stall_d", o_data, 64'h1000_0000); chk("stall_t", o_tag, 10);
            go();
        end
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp(); chk("b2b_v", o_valid, 1); chk("b2b_d", o_data, 64'h1000_0000 + 64'(i)); chk("b2b_t", o_tag, 5'(10 + i));
            go();
        end
        smp(); chk("b2b_end", o_valid, 0); go();

        // flush with a response in the flush cycle
        for (int i = 0; i < 3; i++) begin
            req(4'd4, 3'd0, 64'd0, 5'(20 + i)); go();
        end
        idle(); fl = 1'b1; rsp(64'hDEAD_0000);
        smp(); chk("flush_rdy", req_ready, 0); go();
        fl = 1'b0; rsp(64'hDEAD_0001);
        smp(); chk("killed_v1", o_valid, 0); go();
        rsp(64'hDEAD_0002);
        smp(); chk("killed_v2", o_valid, 0); go();
        idle(); req(4'd4, 3'd0, 64'd0, 5'd23); go();
        idle(); rsp(64'h1234_5678); go();
        idle();
        get("post_flush", 64'h1234_5678, 5'd23, 1'b0);
        chk("flush_pe", pe, 0);

        run_random(1500);

        resetn = 1'b0; go(); resetn = 1'b1; go();
        sel = 1'b1;

        // 64-bit lanes
        ordy = 1'b0;
        req(4'd8, 3'd0, 64'd0, 5'd1); go();
        req(4'd4, 3'd4, 64'd0, 5'd2); go();
        idle(); rsp(64'h8000_0001_0000_0002); go();
        rsp(64'h8000_0001_0000_0002); go();
        idle(); ordy = 1'b1;
        get("ld64", 64'h8000_0001_0000_0002, 5'd1, 1'b0);
        get("lw64", 64'hFFFF_FFFF_8000_0001, 5'd2, 1'b0);
        smp();
        rt = 4'd9; ro = 3'd0; #1; chk("t9_adel", req_adel, 1);
        rt = 4'd8; ro = 3'd4; #1; chk("ld_mis", req_adel, 1);
        rt = 4'd5; #1; chk("lwu64_ok", req_adel, 0);
        go();

        // stray response sets sticky proto_err, cleared only by reset
        rsp(64'd1); go();
        idle();
        smp(); chk("proto", pe, 1); go();
        go();
        smp(); chk("proto_sticky", pe, 1);
        resetn = 1'b0; #1;
        chk("areset_pe", pe, 0);
        chk("areset_rdy", req_ready, 1);
        go(); resetn = 1'b1; go();

        run_random(1500);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
